// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative AES MixColumns stage for the round datapath, placed between
// shift_rows and AddRoundKey. It accepts one 128-bit state per valid/ready
// handshake and rewrites one 32-bit column per clock, so a full state takes
// four CALC cycles. When last_round is set with the state, MixColumns is
// skipped and the state is presented unchanged on the next cycle. The result
// is held until the consumer takes it.
//
// Byte layout is column-major: column c occupies bits [32c : 32c+31], row r of
// that column occupies bits [32c+8r : 32c+8r+7], and bit 0 of every byte is
// its MSB.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    state_in / last_round valid
//   in_ready    stage can accept a state this cycle
//   state_in    state from shift_rows
//   last_round  sampled with state_in; 1 = bypass MixColumns
//   out_valid   state_out valid
//   out_ready   consumer accepts state_out this cycle
//   state_out   transformed state
//   busy        stage holds a state
// -----------------------------------------------------------------------------
module mix_columns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   col;
    logic [0:127] work;

    logic         accept;
    logic [0:31]  col_in;
    logic [0:31]  col_out;

    // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    // Bit 0 is the MSB, so a left shift keeps bits [1:7] and appends a zero.
    function automatic logic [0:7] xtime(input logic [0:7] x);
        return {x[1:7], 1'b0} ^ (x[0] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column: multiply by the circulant matrix
    // [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]. 3*x is computed as 2*x ^ x.
    function automatic logic [0:31] mix_column(input logic [0:31] a);
        logic [0:7] a0, a1, a2, a3;
        logic [0:7] d0, d1, d2, d3;
        logic [0:7] b0, b1, b2, b3;
        a0 = a[0:7];
        a1 = a[8:15];
        a2 = a[16:23];
        a3 = a[24:31];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        b0 = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
        b3 = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
        return {b0, b1, b2, b3};
    endfunction

    // in_ready is the only output with a combinational path from an input:
    // a finished state may be replaced in the same cycle it is consumed.
    // It is gated by rst_n so nothing is handshaken while reset is held.
    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here a default first), otherwise synthesis infers a latch.
    always_comb begin
        col_in  = '0;
        col_in  = work[{col, 5'd0} +: 32];
        col_out = mix_column(col_in);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the 128-bit working register is deliberately reset: it
            // drives state_out directly, and a discarded partial result must
            // never be visible after reset.
            state <= IDLE;
            col   <= 2'd0;
            work  <= '0;
        end else if (accept) begin
            // A new state can only arrive in IDLE or in DONE while the old
            // result is consumed; both cases load the same way.
            work  <= state_in;
            col   <= 2'd0;
            state <= last_round ? DONE : CALC;
        end else begin
            case (state)
                CALC: begin
                    work[{col, 5'd0} +: 32] <= col_out;
                    col                     <= col + 2'd1;
                    // The counter wraps 3 -> 0 on the same edge.
                    if (col == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = work;

    // A presented result stays put until the consumer takes it.
    hold_stable_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(state_out))
    );

    // New states are never taken while columns are being computed.
    no_accept_in_calc_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == CALC) |-> !in_ready
    );

endmodule

// File: tb/tb_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_iter
//
// Self-checking bench for mix_columns_iter. Stimulus pushes the reference
// result of each accepted state into a queue; an independent monitor pops and
// compares on every output handshake and watches that held outputs stay put.
// The reference model is a plain GF(2^8) matrix product on byte arrays.
// -----------------------------------------------------------------------------
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] state_in = '0;
    logic         last_round = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] state_out;
    logic         busy;

    mix_columns_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_sent = 0;
    int n_out = 0;
    bit rand_ready = 1'b0;
    bit ready_req = 1'b1;
    logic [127:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready changes 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Carry-less product followed by reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p ^= (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input bit last);
        int base[4] = '{2, 3, 1, 1};
        logic [7:0] a[4][4];
        logic [7:0] acc;
        logic [127:0] res;
        if (last) return s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[c][r] = s[127 - 32*c - 8*r -: 8];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(a[c][k], 8'(base[(k - r + 4) % 4]));
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        return res;
    endfunction

    // Monitor: result comparison on handshake, stability under backpressure.
    bit           hold_pending = 1'b0;
    logic [127:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_int("hold_valid", int'(out_valid), 1);
                check("hold_data", state_out, held);
            end
            if (out_valid && !out_ready)
                check_int("hold_in_ready", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0)
                    check("unexpected_output", state_out, 128'h0 ^ ~state_out);
                else
                    check("result", state_out, exp_q.pop_front());
            end
            hold_pending = out_valid && !out_ready;
            held = state_out;
        end
    end

    // Present a state until it is accepted; returns the accept edge number.
    task automatic send(input logic [127:0] s, input bit last, output int acc_cyc);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        state_in = s;
        last_round = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_model(s, last));
                n_sent++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
        if (!done) check_int("accept_timeout", int'(done), 1);
    endtask

    // Watch 12 cycles after an accept: latency in edges and busy cycle count.
    task automatic observe(input int acc_cyc, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (out_valid && lat < 0) lat = cyc - acc_cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [127:0] APPB_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] APPB_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] KNOWN_IN = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
    localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, bcnt, k;
        logic [127:0] s;

        // Reference model sanity against published vectors.
        check("model_appb", ref_model(APPB_IN, 1'b0), APPB_OUT);
        check("model_known", ref_model(KNOWN_IN, 1'b0), 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6);

        // Reset values.
        idle_cycles(3);
        @(negedge clk);
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check("rst_state_out", state_out, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_int("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Round 1 of FIPS-197 Appendix B.
        send(APPB_IN, 1'b0, acc);
        observe(acc, lat, bcnt);
        check_int("appb_latency", lat, 4);
        check_int("appb_busy_cycles", bcnt, 5);

        // Known column vectors.
        send(KNOWN_IN, 1'b0, acc);
        observe(acc, lat, bcnt);
        check_int("known_latency", lat, 4);

        // Final-round bypass.
        send(BYP_IN, 1'b1, acc);
        observe(acc, lat, bcnt);
        check_int("bypass_latency", lat, 0);
        check_int("bypass_busy_cycles", bcnt, 1);

        // Backpressure: hold the result 10 cycles while a new state waits.
        ready_req = 1'b0;
        idle_cycles(1);
        send(APPB_IN, 1'b0, acc);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_int("bp_valid_seen", int'(out_valid), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        state_in = KNOWN_IN;
        last_round = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        ready_req = 1'b1;
        send(KNOWN_IN, 1'b0, acc);
        check_int("bp_same_cycle_accept", acc, cyc);
        @(negedge clk);
        check_int("bp_next_calc", int'({out_valid, busy}), 1);
        idle_cycles(8);
        check_int("bp_drained", exp_q.size(), 0);

        // Reset in the middle of CALC.
        send(APPB_IN, 1'b0, acc);
        idle_cycles(1);
        rst_n = 1'b0;
        #1;
        check_int("midrst_out_valid", int'(out_valid), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_in_ready", int'(in_ready), 0);
        check("midrst_state_out", state_out, 128'h0);
        exp_q.delete();
        n_sent--;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        send(APPB_IN, 1'b0, acc);
        observe(acc, lat, bcnt);
        check_int("postrst_latency", lat, 4);

        // Random stream with mixed bypass and random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            send(s, 1'($urandom_range(0, 1)), acc);
            idle_cycles($urandom_range(0, 2));
        end
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            idle_cycles(1);
            k++;
        end
        rand_ready = 1'b0;
        idle_cycles(3);
        check_int("stream_drained", exp_q.size(), 0);
        check_int("output_count", n_out, n_sent);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
